// File: rtl/sodor5_stim_sequencer.sv
// Stimulus sequencer for the sodor5 model-vs-core environment: seeds both
// register files, streams random ALU-immediate instructions, then drains.
module sodor5_stim_sequencer #(
    parameter int          NUM_REGS     = 32,
    parameter int          WORD_SIZE    = 32,
    parameter int          NUM_INSTRS   = 100,
    parameter int          DRAIN_CYCLES = 5,
    parameter logic [31:0] SEED         = 32'h00000001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          issued_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] TAPS     = 32'h80200003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    // Shift-immediate forms keep only legal shamt/funct7 bits.
    function automatic logic [31:0] build(input logic [31:0] x);
        logic [11:0] imm;
        imm = x[31:20];
        if (x[14:12] == 3'd1)
            imm &= 12'h01F;
        else if (x[14:12] == 3'd5)
            imm &= 12'h41F;
        return {imm, x[19:7], 7'b0010011};
    endfunction

    state_t      state, next_state;
    logic [31:0] lfsr, lfsr_d;
    logic [4:0]  idx, idx_d;
    logic [15:0] drain_cnt, drain_d;
    logic [15:0] cnt_d, count_inc;
    logic        accept, last_reg, last_instr, last_nop;

    assign accept     = instr_valid && instr_ready;
    assign count_inc  = (issued_count == 16'hFFFF) ? issued_count
                                                   : issued_count + 16'd1;
    assign last_reg   = (idx == 5'(NUM_REGS - 1));
    assign last_instr = (count_inc == 16'(NUM_INSTRS));
    assign last_nop   = (drain_cnt == 16'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (start) next_state = S_INIT;
            S_INIT:  if (last_reg) next_state = S_RUN;
            S_RUN:   if (accept && last_instr) next_state = S_DRAIN;
            S_DRAIN: if (accept && last_nop) next_state = S_DONE;
            S_DONE:  if (start) next_state = S_INIT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d  = lfsr;
        idx_d   = idx;
        cnt_d   = issued_count;
        drain_d = drain_cnt;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d = SEED_EFF;
                    idx_d  = 5'd0;
                    cnt_d  = 16'd0;
                end
            end
            S_INIT: begin
                lfsr_d = lfsr_step(lfsr);
                idx_d  = idx + 5'd1;
            end
            S_RUN: begin
                drain_d = 16'd0;
                if (accept) begin
                    lfsr_d = lfsr_step(lfsr);
                    cnt_d  = count_inc;
                end
            end
            S_DRAIN: begin
                if (accept) drain_d = drain_cnt + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= SEED_EFF;
            idx          <= 5'd0;
            drain_cnt    <= 16'd0;
            issued_count <= 16'd0;
            rf_wen       <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= '0;
            instr_valid  <= 1'b0;
            instr        <= WORD_SIZE'(NOP);
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            lfsr         <= lfsr_d;
            idx          <= idx_d;
            drain_cnt    <= drain_d;
            issued_count <= cnt_d;
            rf_wen       <= (next_state == S_INIT);
            rf_waddr     <= (next_state == S_INIT) ? idx_d : 5'd0;
            rf_wdata     <= (next_state == S_INIT && idx_d != 5'd0)
                            ? WORD_SIZE'(lfsr_d) : '0;
            instr_valid  <= (next_state == S_RUN) || (next_state == S_DRAIN);
            instr        <= (next_state == S_RUN) ? WORD_SIZE'(build(lfsr_d))
                                                  : WORD_SIZE'(NOP);
            busy         <= (next_state == S_INIT) || (next_state == S_RUN)
                            || (next_state == S_DRAIN);
            done         <= (next_state == S_DONE);
        end
    end

endmodule

// File: doc/sodor5_stim_sequencer.md
Name: sodor5_stim_sequencer

Overview:
Stimulus controller for the sodor5 model-vs-core verification environment. After a start pulse it:
- seeds the model and core register files identically through a shared write port;
- issues a bounded stream of pseudo-random RV32I ALU-immediate instructions over a valid/ready instruction channel;
- drains the pipeline with NOPs, then signals completion.

It sits between the bench top and the imem-response/regfile-preload inputs of the model and the core.

Parameters:
NUM_REGS, 32, number of architectural registers preloaded
WORD_SIZE, 32, register/instruction width in bits
NUM_INSTRS, 100, random instructions issued per run (>=1)
DRAIN_CYCLES, 5, NOPs issued after the last random instruction (>=1)
SEED, 32'h00000001, LFSR seed; a value of 0 is replaced by 1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; honoured only in IDLE or DONE
rf_wen  output  1  regfile preload write enable
rf_waddr  output  5  preload register index
rf_wdata  output  WORD_SIZE  preload data
instr_valid  output  1  instr holds an instruction to issue
instr_ready  input  1  core/model accepts instr this cycle
instr  output  WORD_SIZE  instruction word
busy  output  1  high in INIT, RUN, DRAIN
done  output  1  high in DONE
issued_count  output  16  random instructions accepted in the current run

Behaviour:
- All outputs are registered.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, instr_valid=0, instr=32'h00000013, busy=0, done=0, issued_count=0. The LFSR is loaded with SEED (or 1 if SEED=0). The state goes to IDLE.
- Reset asserted in any state, including mid-run, returns everything to these values on the next edge.
- LFSR: 32-bit Galois.
  - next = lfsr[0] ? (lfsr>>1) ^ 32'h80200003 : lfsr>>1
  - Advances only where stated below.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE: instr_valid=0. When start=1, go to INIT with preload index 0.
- INIT: one write per cycle for NUM_REGS cycles, no stalls.
  - rf_wen=1, rf_waddr=index.
  - rf_wdata = 0 when index=0, otherwise the current lfsr.
  - The LFSR advances every INIT cycle, including index 0.
  - After index NUM_REGS-1, go to RUN next cycle with rf_wen=0.
- RUN: instr_valid=1; instr is built from the current lfsr:
  - imm=lfsr[31:20], rs1=lfsr[19:15], funct3=lfsr[14:12], rd=lfsr[11:7], opcode=7'b0010011.
  - Shift legality: funct3=1 -> imm &= 12'h01F; funct3=5 -> imm &= 12'h41F.
  - On instr_valid && instr_ready: issued_count increments and the LFSR advances; the next instr reflects the new lfsr one cycle later.
  - While instr_ready=0, instr and instr_valid hold stable.
  - The acceptance that brings issued_count to NUM_INSTRS moves the state to DRAIN.
- DRAIN: instr_valid=1, instr=32'h00000013.
  - Count accepted NOPs; after DRAIN_CYCLES acceptances go to DONE.
  - The LFSR does not advance.
- DONE: instr_valid=0, done=1, busy=0, issued_count held.
  - start in DONE reloads the LFSR from SEED, clears issued_count and done, and enters INIT.
- start in INIT/RUN/DRAIN is ignored.
- busy and done are never both high.
- issued_count saturates at 16'hFFFF; with NUM_INSTRS<=65535 it never wraps.

Test Plan:
1. SEED=1, pulse start -> next cycle rf_wen=1, waddr=0, wdata=0; following cycle waddr=1, wdata=32'h80200003; exactly 32 consecutive writes with waddr 0..31.
2. instr_ready tied 1, NUM_INSTRS=100, DRAIN_CYCLES=5 -> exactly 100 instrs with opcode 0x13, then 5 instrs of 0x00000013; done=1 and issued_count=100 thereafter; instr_valid=0 in DONE.
3. instr_ready toggled randomly -> instr stable whenever valid && !ready; total accepted random instrs still 100; accepted sequence identical to the ready-always-1 run.
4. Every accepted instr with funct3=1 has imm[11:5]=0; every accepted instr with funct3=5 has imm[11]=0 and imm[9:5]=0.
5. reset asserted mid-RUN (issued_count=37) -> next edge: all outputs at reset values, state IDLE; a fresh start reproduces the scenario-1 write sequence.
6. start pulsed during RUN -> ignored (count continues); start in DONE -> rerun reproduces the identical instruction stream; SEED=0 gives the same stream as SEED=1.
